ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the IF/ID pair. It consumes the decoded operands, funct3 and rd carried over from ID, and computes one M-extension result over several cycles. While it computes, it drives a stall that the hazard logic uses to deassert PC_write and IF_ID_write. The finished result and destination register go to the EX/MEM path with a one-cycle done pulse.

---
 rtl/ex_muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiplies with a radix-2 shift-add and divides with a restoring
// shift-subtract, one bit per cycle, on operand magnitudes; the result
// sign is fixed up in a single cycle at the end. Divide-by-zero and the
// signed overflow case finish in one cycle without iterating.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      FUNCT3_EX,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic [4:0]      RD_EX,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] RESULT,
  output logic [4:0]      RD_OUT
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic                neg_q, neg_d;

  logic                is_div, op1_signed, op2_signed, sign1, sign2;
  logic                div_zero, div_ovf, acc_neg;
  logic [XLEN-1:0]     mag1, mag2;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
  logic [XLEN:0]       rem_sh;
  logic [XLEN-1:0]     div_diff, quo_fix, rem_fix, fix_result;
  logic                div_ge;

  // Decode the incoming request: operand signedness, magnitudes, result sign and the one-cycle special cases
  always_comb begin
    is_div     = FUNCT3_EX[2];
    op1_signed = is_div ? ~FUNCT3_EX[0] : (FUNCT3_EX[1:0] == 2'b01 || FUNCT3_EX[1:0] == 2'b10);
    op2_signed = is_div ? ~FUNCT3_EX[0] : (FUNCT3_EX[1:0] == 2'b01);
    sign1      = op1_signed & OPERAND1[XLEN-1];
    sign2      = op2_signed & OPERAND2[XLEN-1];
    mag1       = sign1 ? (~OPERAND1 + 1'b1) : OPERAND1;
    mag2       = sign2 ? (~OPERAND2 + 1'b1) : OPERAND2;
    acc_neg    = (is_div && FUNCT3_EX[1]) ? sign1 : (sign1 ^ sign2);
    div_zero   = is_div && (OPERAND2 == '0);
    div_ovf    = is_div && !FUNCT3_EX[0] && (OPERAND1 == INT_MIN) && (OPERAND2 == '1);
  end

  // One iteration of shift-add multiply and of restoring divide on the accumulator
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge   = rem_sh >= {1'b0, opb_q};
    div_diff = rem_sh[XLEN-1:0] - opb_q;
    div_next = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                      : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // Sign correction and selection of product half, quotient or remainder
  always_comb begin
    prod_fix   = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix    = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix    = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    fix_result = prod_fix[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      fix_result = op_q[1] ? rem_fix : quo_fix;
    end else if (op_q[1:0] == 2'b00) begin
      fix_result = prod_fix[XLEN-1:0];
    end
  end

  // Next-state logic; flush wins over everything and leaves the result untouched
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    result_d = result_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            op_d  = FUNCT3_EX;
            rd_d  = RD_EX;
            cnt_d = '0;
            acc_d = {{XLEN{1'b0}}, mag1};
            opb_d = mag2;
            neg_d = acc_neg;
            if (div_zero) begin
              result_d = FUNCT3_EX[1] ? OPERAND1 : {XLEN{1'b1}};
              state_d  = DONE;
            end else if (div_ovf) begin
              result_d = FUNCT3_EX[1] ? {XLEN{1'b0}} : INT_MIN;
              state_d  = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = FIX;
          end
        end
        FIX: begin
          result_d = fix_result;
          state_d  = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by reset low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      result_q <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
    end
  end

  // Status outputs; stall covers the accept cycle so the pipeline freezes immediately
  always_comb begin
    busy   = (state_q == CALC) || (state_q == FIX);
    done   = (state_q == DONE);
    stall  = (start && (state_q == IDLE || state_q == DONE)) || busy;
    RESULT = result_q;
    RD_OUT = rd_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: expected results come from a
// behavioural model using native 64-bit arithmetic and are queued when
// an op is started, then popped and compared when done pulses.
module tb_ex_muldiv_unit;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  FUNCT3_EX;
  logic [31:0] OPERAND1;
  logic [31:0] OPERAND2;
  logic [4:0]  RD_EX;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] RESULT;
  logic [4:0]  RD_OUT;

  int   checks = 0;
  int   errors = 0;
  exp_t sbQ[$];
  logic [31:0] lastRes = 32'h0;

  ex_muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .FUNCT3_EX(FUNCT3_EX),
    .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .RD_EX(RD_EX), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .RESULT(RESULT), .RD_OUT(RD_OUT)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation and count it
  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of the RV32M operations
  function automatic logic [31:0] modelOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
      3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return $signed(a) / $signed(b);
      end
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int modelLat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if (f[2] && !f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  // Drive one request for a cycle; optionally queue its expected outcome
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input bit push);
    exp_t e;
    start = 1'b1; FUNCT3_EX = f; OPERAND1 = a; OPERAND2 = b; RD_EX = rd;
    #1;
    checkOutput("stall_at_start", stall, 1);
    if (push) begin
      e.res = modelOp(f, a, b);
      e.rd  = rd;
      e.lat = modelLat(f, a, b);
      sbQ.push_back(e);
    end
    step();
    start = 1'b0;
    #1;
  endtask

  // Wait for done, checking latency, stall coverage and the scoreboard head
  task automatic waitDone(input int midStart);
    exp_t e;
    int   lat;
    bit   stallBad;
    lat = 1;
    stallBad = 0;
    while (!done && lat < 60) begin
      if (!stall) stallBad = 1;
      if (lat == midStart) begin
        start = 1'b1; FUNCT3_EX = 3'b011; OPERAND1 = 32'h12345678;
        OPERAND2 = 32'h9ABCDEF0; RD_EX = 5'd31;
      end
      step();
      start = 1'b0;
      #1;
      lat++;
    end
    checkOutput("done_seen", done, 1);
    checkOutput("sb_nonempty", sbQ.size() != 0, 1);
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      checkOutput("latency", lat, e.lat);
      checkOutput("result", RESULT, e.res);
      checkOutput("rd_out", RD_OUT, e.rd);
      lastRes = e.res;
    end
    checkOutput("stall_until_done", stallBad, 0);
    checkOutput("stall_released", stall, 0);
    checkOutput("busy_in_done", busy, 0);
  endtask

  task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    applyStimulus(f, a, b, rd, 1);
    waitDone(0);
  endtask

  task automatic expectNoDone(input string tag, input int cycles);
    bit saw;
    saw = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) saw = 1;
      step();
    end
    checkOutput(tag, saw, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    FUNCT3_EX = 3'b0; OPERAND1 = 32'h0; OPERAND2 = 32'h0; RD_EX = 5'd0;
    #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_result", RESULT, 0);
    checkOutput("rst_rd", RD_OUT, 0);
    checkOutput("rst_stall", stall, 0);
    #10;
    reset = 1'b1;
    step();

    $display("[TB] multiply tests");
    runOp(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5);
    step();
    checkOutput("done_one_cycle", done, 0);
    runOp(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6);
    runOp(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7);
    runOp(3'b010, 32'hFFFFFFFF, 32'd2, 5'd8);

    $display("[TB] divide tests");
    runOp(3'b100, 32'hFFFFFFF9, 32'd2, 5'd9);
    runOp(3'b110, 32'hFFFFFFF9, 32'd2, 5'd10);
    runOp(3'b101, 32'd100, 32'd7, 5'd11);
    runOp(3'b111, 32'd100, 32'd7, 5'd12);

    $display("[TB] special cases");
    runOp(3'b101, 32'd1234, 32'd0, 5'd13);
    runOp(3'b110, 32'd1234, 32'd0, 5'd14);
    runOp(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15);
    runOp(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16);

    $display("[TB] random ops");
    for (int i = 0; i < 8; i++) begin
      runOp(3'($urandom_range(0, 7)), $urandom, (i == 3) ? 32'd0 : $urandom, 5'($urandom_range(1, 31)));
    end

    $display("[TB] flush test");
    applyStimulus(3'b000, 32'd3, 32'd5, 5'd20, 0);
    for (int i = 1; i < 10; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    checkOutput("flush_busy", busy, 0);
    checkOutput("flush_stall", stall, 0);
    expectNoDone("flush_no_done", 40);
    checkOutput("flush_result_kept", RESULT, lastRes);
    applyStimulus(3'b000, 32'd1000, 32'd2000, 5'd21, 1);
    waitDone(5);

    $display("[TB] reset test");
    applyStimulus(3'b100, 32'd1000, 32'd3, 5'd22, 0);
    for (int i = 1; i < 20; i++) step();
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_result", RESULT, 0);
    checkOutput("midrst_rd", RD_OUT, 0);
    checkOutput("midrst_stall", stall, 0);
    #3;
    reset = 1'b1;
    expectNoDone("rst_no_done", 40);

    $display("[TB] back-to-back test");
    applyStimulus(3'b000, 32'hDEADBEEF, 32'h00001234, 5'd23, 1);
    waitDone(0);
    applyStimulus(3'b100, 32'hFFFF0000, 32'd7, 5'd24, 1);
    waitDone(0);
    checkOutput("sb_drained", sbQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
